// File: rtl/rib_master_arbiter.sv
// rib_master_arbiter: merges the ibus (master 0) and dbus (master 1) RIB ports onto one
// RIB master port. Address phases are round-robin arbitrated; an in-order owner FIFO
// steers each data-phase response back to the master that issued the request.
module rib_master_arbiter #(
    parameter int OUTSTD = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [AW-1:0]   i_m0_addr,
    input  logic            i_m0_wrcs,
    input  logic [DW/8-1:0] i_m0_mask,
    input  logic [DW-1:0]   i_m0_wdata,
    input  logic            i_m0_req,
    output logic            o_m0_gnt,
    output logic            o_m0_rsp,
    output logic [DW-1:0]   o_m0_rdata,
    input  logic            i_m0_rdy,
    input  logic [AW-1:0]   i_m1_addr,
    input  logic            i_m1_wrcs,
    input  logic [DW/8-1:0] i_m1_mask,
    input  logic [DW-1:0]   i_m1_wdata,
    input  logic            i_m1_req,
    output logic            o_m1_gnt,
    output logic            o_m1_rsp,
    output logic [DW-1:0]   o_m1_rdata,
    input  logic            i_m1_rdy,
    output logic [AW-1:0]   o_s_addr,
    output logic            o_s_wrcs,
    output logic [DW/8-1:0] o_s_mask,
    output logic [DW-1:0]   o_s_wdata,
    output logic            o_s_req,
    input  logic            i_s_gnt,
    input  logic [DW-1:0]   i_s_rdata,
    input  logic            i_s_rsp,
    output logic            o_s_rdy,
    output logic            o_err
);

    localparam int PW = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;
    localparam int CW = $clog2(OUTSTD + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTD - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OUTSTD);

    logic [OUTSTD-1:0] owner;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              rr_last;
    logic              err;
    logic              hold_valid;
    logic              hold_sel;

    logic full;
    logic empty;
    logic sel;
    logic head;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Pick the master to present: a stalled selection is kept until its request drops,
    // otherwise the lone requester, or on a tie the master not granted last.
    always_comb begin
        full  = (count == CNT_FULL);
        empty = (count == '0);
        if (hold_valid && (hold_sel ? i_m1_req : i_m0_req))
            sel = hold_sel;
        else if (i_m0_req && i_m1_req)
            sel = ~rr_last;
        else
            sel = i_m1_req;
    end

    assign o_s_addr  = sel ? i_m1_addr  : i_m0_addr;
    assign o_s_wrcs  = sel ? i_m1_wrcs  : i_m0_wrcs;
    assign o_s_mask  = sel ? i_m1_mask  : i_m0_mask;
    assign o_s_wdata = sel ? i_m1_wdata : i_m0_wdata;
    assign o_s_req   = (i_m0_req | i_m1_req) & ~full;
    assign push      = o_s_req & i_s_gnt;
    assign o_m0_gnt  = push & ~sel;
    assign o_m1_gnt  = push & sel;

    assign head       = owner[rd_ptr];
    assign o_s_rdy    = ~empty & (head ? i_m1_rdy : i_m0_rdy);
    assign o_m0_rsp   = i_s_rsp & ~empty & ~head;
    assign o_m1_rsp   = i_s_rsp & ~empty & head;
    assign o_m0_rdata = i_s_rdata;
    assign o_m1_rdata = i_s_rdata;
    assign pop        = i_s_rsp & o_s_rdy;
    assign o_err      = err;

    // Owner entries: record which master each accepted address phase belongs to.
    // NOTE: the owner storage has no reset; an entry is only read while count says it is valid.
    always_ff @(posedge i_clk) begin
        if (push)
            owner[wr_ptr] <= sel;
    end

    // FIFO pointers/occupancy, round-robin history, stall lock and sticky error.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rr_last    <= 1'b0;
            err        <= 1'b0;
            hold_valid <= 1'b0;
            hold_sel   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr  <= ptr_next(wr_ptr);
                rr_last <= sel;
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            count      <= count + CW'(push) - CW'(pop);
            hold_valid <= o_s_req & ~i_s_gnt;
            hold_sel   <= sel;
            if (i_s_rsp && empty)
                err <= 1'b1;
        end
    end

endmodule
